bus_controller: RTL and testbench

Memory/I-O bus controller directly downstream of `Processador`. It accepts one word access at a time over a req/ack handshake and decodes the address into four regions: instruction ROM, data RAM, LED output register and switch input port. It drives the synchronous ROM/RAM macros and returns read data with a fixed, parameterisable latency. Each processor `ld`, `sd` and fetch is serviced through this block.

---
 rtl/bus_controller_pkg.sv | 29 ++
 rtl/bus_controller_sync2.sv | 24 ++
 rtl/bus_controller.sv | 132 +++++++++++++
 tb/tb_bus_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_controller_pkg.sv
// Shared types and constants for the processor memory/I-O bus controller.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } bus_state_t;

  localparam logic [3:0] REG_ROM = 4'd0;
  localparam logic [3:0] REG_RAM = 4'd1;
  localparam logic [3:0] REG_LED = 4'd2;
  localparam logic [3:0] REG_SW  = 4'd3;

  localparam int LED_W = 10;

  // Illegal access: writes to read-only regions and anything outside the map.
  function automatic logic access_err(input logic [3:0] region, input logic wr);
    logic err;
    case (region)
      REG_RAM, REG_LED: err = 1'b0;
      REG_ROM, REG_SW:  err = wr;
      default:          err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/bus_controller_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // Two-stage resynchronisation into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/bus_controller.sv
// Single-outstanding req/ack bus controller decoding ROM, RAM, LED and switch
// regions, with a fixed access latency of 3+WAIT_STATES cycles.
module bus_controller
  import bus_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MEM_AW      = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  input  logic              Req,
  output logic              Ack,
  output logic [15:0]       DIN,
  output logic [MEM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_q,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [15:0]       ram_d,
  output logic              ram_we,
  input  logic [15:0]       ram_q,
  output logic [LED_W-1:0]  LEDR,
  input  logic [LED_W-1:0]  SW,
  output logic              BusErr
);

  bus_state_t       state_r, state_next_s;
  logic [1:0]       cnt_r;
  logic [3:0]       region_r;
  logic             wr_r;
  logic [LED_W-1:0] led_data_r;
  logic [LED_W-1:0] sw_sync_s;
  logic [15:0]      rd_data_s;
  logic             addr_unused_s;

  // Region-internal high offset bits alias and are intentionally ignored.
  assign addr_unused_s = ^ADDR[11:MEM_AW];

  sync2 #(.W(LED_W)) u_sw_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (SW),
    .q     (sw_sync_s)
  );

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Req) state_next_s = ACCESS;
        else     state_next_s = IDLE;
      end
      ACCESS: state_next_s = WAIT;
      WAIT: begin
        if (cnt_r == 2'd0) state_next_s = RESP;
        else               state_next_s = WAIT;
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Read-data mux; memory data is valid from the first WAIT cycle onward.
  always_comb begin
    rd_data_s = 16'h0000;
    case (region_r)
      REG_ROM: rd_data_s = rom_q;
      REG_RAM: rd_data_s = ram_q;
      REG_LED: rd_data_s = {{(16-LED_W){1'b0}}, LEDR};
      REG_SW:  rd_data_s = {{(16-LED_W){1'b0}}, sw_sync_s};
      default: rd_data_s = 16'h0000;
    endcase
  end

  // Request capture, memory drive, wait counting and response registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_r      <= 2'd0;
      region_r   <= 4'd0;
      wr_r       <= 1'b0;
      led_data_r <= '0;
      rom_addr   <= '0;
      ram_addr   <= '0;
      ram_d      <= 16'h0000;
      ram_we     <= 1'b0;
      Ack        <= 1'b0;
      DIN        <= 16'h0000;
      LEDR       <= '0;
      BusErr     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Req) begin
            region_r   <= ADDR[15:12];
            wr_r       <= W;
            led_data_r <= DOUT[LED_W-1:0];
            cnt_r      <= 2'(WAIT_STATES);
            rom_addr   <= ADDR[MEM_AW-1:0];
            ram_addr   <= ADDR[MEM_AW-1:0];
            ram_d      <= DOUT;
            ram_we     <= W && (ADDR[15:12] == REG_RAM);
          end
        end
        ACCESS: ram_we <= 1'b0;
        WAIT: begin
          if (cnt_r == 2'd0) begin
            Ack <= 1'b1;
            if (!wr_r) DIN <= rd_data_s;
            if (wr_r && (region_r == REG_LED)) LEDR <= led_data_r;
            if (access_err(region_r, wr_r)) BusErr <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        RESP:    Ack <= 1'b0;
        default: Ack <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: table-driven accesses with a
// scoreboard, plus reset, back-to-back, wait-state and mid-access-reset cases.
module tb_bus_controller;
  import bus_pkg::*;

  typedef struct {
    logic [15:0] din;
    logic        err;
    logic [9:0]  ledr;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] din;
    logic        err;
    logic [9:0]  ledr;
    logic        we;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] DOUT = 16'h0000;
  logic        W = 1'b0;
  logic [9:0]  SW = 10'h000;
  logic        req0 = 1'b0, req2 = 1'b0;
  logic        mem_init = 1'b1;

  logic        ack0, ack2, we0, we2, err0, err2;
  logic [15:0] din0, din2, rom_q0, rom_q2, ram_q0, ram_q2, ram_d0, ram_d2;
  logic [6:0]  rom_a0, rom_a2, ram_a0, ram_a2;
  logic [9:0]  ledr0, ledr2;

  logic [15:0] ram0 [128];
  logic [15:0] ram2 [128];

  int   n_pass = 0, n_total = 0;
  int   we_total = 0;
  logic [6:0]  we_addr = 7'd0;
  logic [15:0] we_d = 16'h0000;
  exp_t sb_q[$];
  vec_t vecs[11];

  always #5 Clock = ~Clock;

  bus_controller #(.WAIT_STATES(0), .MEM_AW(7)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .Req(req0),
    .Ack(ack0), .DIN(din0), .rom_addr(rom_a0), .rom_q(rom_q0), .ram_addr(ram_a0),
    .ram_d(ram_d0), .ram_we(we0), .ram_q(ram_q0), .LEDR(ledr0), .SW(SW), .BusErr(err0)
  );

  bus_controller #(.WAIT_STATES(2), .MEM_AW(7)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .Req(req2),
    .Ack(ack2), .DIN(din2), .rom_addr(rom_a2), .rom_q(rom_q2), .ram_addr(ram_a2),
    .ram_d(ram_d2), .ram_we(we2), .ram_q(ram_q2), .LEDR(ledr2), .SW(SW), .BusErr(err2)
  );

  function automatic logic [15:0] rom_word(input logic [6:0] a);
    return (a == 7'd3) ? 16'h3A12 : (16'hC000 | {9'd0, a});
  endfunction

  // One-cycle-latency ROM/RAM models; RAM contents preloaded while mem_init is set.
  always @(posedge Clock) begin
    rom_q0 <= rom_word(rom_a0);
    rom_q2 <= rom_word(rom_a2);
    ram_q0 <= ram0[ram_a0];
    ram_q2 <= ram2[ram_a2];
    if (mem_init) begin
      for (int i = 0; i < 128; i++) begin
        ram0[i] <= 16'h5500 + 16'(i);
        ram2[i] <= 16'h5500 + 16'(i);
      end
    end else begin
      if (we0) ram0[ram_a0] <= ram_d0;
      if (we2) ram2[ram_a2] <= ram_d2;
    end
  end

  // Records every cycle in which dut0 asserts its RAM write strobe.
  always @(negedge Clock) begin
    if (we0 === 1'b1) begin
      we_total = we_total + 1;
      we_addr  = ram_a0;
      we_d     = ram_d0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s: got %h expected %h", name, act, exp_v);
    else n_pass++;
  endtask

  task automatic wait_ack(input int which, output int cyc, output logic got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      if ((which == 0) ? ack0 : ack2) got = 1'b1;
    end
  endtask

  task automatic pop_compare(input int which, input int cyc, input logic got);
    exp_t e;
    e = sb_q.pop_front();
    check("ack_seen", {31'd0, got}, 32'd1);
    check("latency", cyc, e.lat);
    check("din", {16'd0, (which == 0) ? din0 : din2}, {16'd0, e.din});
    check("buserr", {31'd0, (which == 0) ? err0 : err2}, {31'd0, e.err});
    check("ledr", {22'd0, (which == 0) ? ledr0 : ledr2}, {22'd0, e.ledr});
  endtask

  task automatic run_access(input int which, input logic [15:0] a, input logic [15:0] d,
                            input logic wr, input exp_t e);
    int   cyc;
    logic got;
    sb_q.push_back(e);
    @(negedge Clock);
    ADDR = a; DOUT = d; W = wr;
    if (which == 0) req0 = 1'b1; else req2 = 1'b1;
    wait_ack(which, cyc, got);
    req0 = 1'b0; req2 = 1'b0;
    pop_compare(which, cyc, got);
  endtask

  initial begin
    int   cyc, base;
    logic got, seen;

    vecs[0]  = '{16'h1005, 16'hBEEF, 1'b1, 16'h3A12, 1'b0, 10'h000, 1'b1};
    vecs[1]  = '{16'h1005, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 10'h000, 1'b0};
    vecs[2]  = '{16'h0F83, 16'h0000, 1'b0, 16'h3A12, 1'b0, 10'h000, 1'b0};
    vecs[3]  = '{16'h2000, 16'hFFFF, 1'b1, 16'h3A12, 1'b0, 10'h3FF, 1'b0};
    vecs[4]  = '{16'h2000, 16'h0000, 1'b0, 16'h03FF, 1'b0, 10'h3FF, 1'b0};
    vecs[5]  = '{16'h3000, 16'h0000, 1'b0, 16'h0155, 1'b0, 10'h3FF, 1'b0};
    vecs[6]  = '{16'h1010, 16'h1234, 1'b1, 16'h0155, 1'b0, 10'h3FF, 1'b1};
    vecs[7]  = '{16'h1F90, 16'h0000, 1'b0, 16'h1234, 1'b0, 10'h3FF, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0007, 1'b1, 16'h1234, 1'b1, 10'h3FF, 1'b0};
    vecs[9]  = '{16'h7000, 16'h0000, 1'b0, 16'h0000, 1'b1, 10'h3FF, 1'b0};
    vecs[10] = '{16'h3000, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 10'h3FF, 1'b0};

    // Reset held with Req high: nothing may respond.
    SW = 10'h155; ADDR = 16'h0003; W = 1'b0; req0 = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      if (ack0) seen = 1'b1;
    end
    check("rst_no_ack", {31'd0, seen}, 32'd0);
    check("rst_din", {16'd0, din0}, 32'd0);
    check("rst_ledr", {22'd0, ledr0}, 32'd0);
    check("rst_buserr", {31'd0, err0}, 32'd0);
    check("rst_ram_we", {31'd0, we0}, 32'd0);
    check("rst_addrs", {11'd0, rom_a0, ram_a0}, 32'd0);
    check("rst_ram_d", {16'd0, ram_d0}, 32'd0);
    mem_init = 1'b0;
    Resetn = 1'b1;
    sb_q.push_back('{16'h3A12, 1'b0, 10'h000, 3});
    wait_ack(0, cyc, got);
    req0 = 1'b0;
    pop_compare(0, cyc, got);

    // Table of single accesses on the zero-wait-state controller.
    for (int i = 0; i < 11; i++) begin
      base = we_total;
      run_access(0, vecs[i].addr, vecs[i].dout, vecs[i].w,
                 '{vecs[i].din, vecs[i].err, vecs[i].ledr, 3});
      check("ram_we_cycles", we_total - base, vecs[i].we ? 32'd1 : 32'd0);
      if (vecs[i].we) begin
        check("ram_we_addr", {25'd0, we_addr}, {25'd0, vecs[i].addr[6:0]});
        check("ram_we_data", {16'd0, we_d}, {16'd0, vecs[i].dout});
      end
    end

    // Req held high across two reads: second Ack exactly 4 cycles later.
    sb_q.push_back('{16'hBEEF, 1'b1, 10'h3FF, 3});
    sb_q.push_back('{16'h03FF, 1'b1, 10'h3FF, 4});
    @(negedge Clock);
    ADDR = 16'h1005; W = 1'b0; req0 = 1'b1;
    wait_ack(0, cyc, got);
    pop_compare(0, cyc, got);
    ADDR = 16'h2000;
    wait_ack(0, cyc, got);
    req0 = 1'b0;
    pop_compare(0, cyc, got);

    // Two wait states.
    run_access(1, 16'h0003, 16'h0000, 1'b0, '{16'h3A12, 1'b0, 10'h000, 5});
    run_access(1, 16'h0F83, 16'h0000, 1'b0, '{16'h3A12, 1'b0, 10'h000, 5});

    // Reset during the ACCESS cycle of a RAM write.
    @(negedge Clock);
    ADDR = 16'h1002; DOUT = 16'h9999; W = 1'b1; req0 = 1'b1;
    @(posedge Clock);
    #1 check("mid_we_high", {31'd0, we0}, 32'd1);
    #1 Resetn = 1'b0;
    #1 check("mid_we_drop", {31'd0, we0}, 32'd0);
    req0 = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge Clock);
      if (ack0) seen = 1'b1;
    end
    check("mid_no_ack", {31'd0, seen}, 32'd0);
    Resetn = 1'b1;
    check("mid_ram_word", {16'd0, ram0[2]}, 32'h5502);
    check("mid_buserr_clr", {31'd0, err0}, 32'd0);
    check("mid_ledr_clr", {22'd0, ledr0}, 32'd0);
    run_access(0, 16'h1002, 16'h0000, 1'b0, '{16'h5502, 1'b0, 10'h000, 3});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
